// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash JEDEC Read-ID sequencer.
//   state_e      : sequencer states
//   CMD_RDID     : JEDEC Read-ID opcode
//   RDID_BITS    : bits clocked per transaction (opcode + three ID bytes)
//   ID_BYTES     : number of ID bytes captured
//   id_is_blank(): true when the captured ID is all zeros or all ones,
//                  which is what a missing or unpowered device returns
package spi_flash_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, DONE} state_e;

  localparam logic [7:0] CMD_RDID  = 8'h9F;
  localparam int         RDID_BITS = 32;
  localparam int         ID_BYTES  = 3;

  function automatic logic id_is_blank(input logic [ID_BYTES*8-1:0] v);
    return (v == '0) || (v == '1);
  endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// SCK half-period timer. Counts 0..CLK_DIV-1 while enabled and raises tick_o
// on the terminal count, i.e. on the last system cycle of each half-period.
//   clk     : system clock
//   reset   : synchronous, active-high reset
//   clr_i   : synchronous clear, counter returns to 0
//   en_i    : count enable
//   tick_o  : half-period boundary (terminal count while enabled)
module spi_phase_timer #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [7:0] TC = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q;

  assign tick_o = en_i && (cnt_q == TC);

  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= tick_o ? 8'd0 : cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/spi_jedec_id_reader.sv
// JEDEC Read-ID (0x9F) sequencer for the board SPI flash (mode 0).
// Shifts out the opcode, clocks in three ID bytes and holds them on
// registered outputs for the display muxes. Runs once after reset when
// AUTO_START is set, then once per accepted start.
//   clk, reset                   : system clock, sync active-high reset
//   start                        : read request, only looked at in IDLE
//   spi_miso                     : flash data in
//   spi_cs_n, spi_sck, spi_mosi  : flash pins, all straight from flops
//   busy                         : transaction in progress (through DONE)
//   done                         : one-cycle pulse when results update
//   id_valid                     : sticky, first result has landed
//   id_error                     : last result was all-0 or all-1
//   manufacture_id, memory_type,
//   memory_capacity              : captured ID bytes, in receive order
module spi_jedec_id_reader #(
  parameter int unsigned CLK_DIV    = 2,
  parameter logic [7:0]  CMD_RDID   = spi_flash_pkg::CMD_RDID,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       spi_miso,
  output logic       spi_cs_n,
  output logic       spi_sck,
  output logic       spi_mosi,
  output logic       busy,
  output logic       done,
  output logic       id_valid,
  output logic       id_error,
  output logic [7:0] manufacture_id,
  output logic [7:0] memory_type,
  output logic [7:0] memory_capacity
);

  import spi_flash_pkg::*;

  localparam int         SR_W     = ID_BYTES * 8;
  localparam logic [5:0] LAST_BIT = 6'(RDID_BITS - 1);
  localparam logic [5:0] CMD_LEN  = 6'd8;

  state_e          state_q;
  logic            auto_q;     // pending one-shot launch after reset
  logic [5:0]      bit_q;
  logic [7:0]      cmd_q;      // remaining opcode bits, MSB next; zeros after
  logic [SR_W-1:0] sr_q;
  logic            cs_n_q, sck_q, mosi_q;
  logic            busy_q, done_q, valid_q, error_q;
  logic [SR_W-1:0] id_q;
  logic            tick;

  // Counter is held at 0 outside SHIFT/HOLD so every transaction starts
  // with a full low half-period.
  spi_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr_i ((state_q == IDLE) || (state_q == DONE)),
    .en_i  ((state_q == SHIFT) || (state_q == HOLD)),
    .tick_o(tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      auto_q  <= AUTO_START;
      bit_q   <= '0;
      cmd_q   <= '0;
      sr_q    <= '0;
      cs_n_q  <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      id_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (start || auto_q) begin
            auto_q  <= 1'b0;
            state_q <= SHIFT;
            bit_q   <= '0;
            cs_n_q  <= 1'b0;
            sck_q   <= 1'b0;
            mosi_q  <= CMD_RDID[7];
            cmd_q   <= {CMD_RDID[6:0], 1'b0};
            busy_q  <= 1'b1;
          end
        end
        SHIFT: begin
          if (tick) begin
            if (!sck_q) begin
              // Rising edge: sample; opcode-phase samples are don't-care.
              sck_q <= 1'b1;
              if (bit_q >= CMD_LEN) sr_q <= {sr_q[SR_W-2:0], spi_miso};
            end else begin
              // Falling edge: present next bit (zeros once opcode is out).
              sck_q  <= 1'b0;
              mosi_q <= cmd_q[7];
              cmd_q  <= {cmd_q[6:0], 1'b0};
              bit_q  <= bit_q + 6'd1;
              if (bit_q == LAST_BIT) state_q <= HOLD;
            end
          end
        end
        HOLD: begin
          if (tick) begin
            state_q <= DONE;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
            done_q  <= 1'b1;
            id_q    <= sr_q;
            valid_q <= 1'b1;
            error_q <= id_is_blank(sr_q);
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign spi_cs_n        = cs_n_q;
  assign spi_sck         = sck_q;
  assign spi_mosi        = mosi_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign id_valid        = valid_q;
  assign id_error        = error_q;
  assign manufacture_id  = id_q[23:16];
  assign memory_type     = id_q[15:8];
  assign memory_capacity = id_q[7:0];

endmodule

// File: tb/tb_spi_jedec_id_reader.sv
// Bench for spi_jedec_id_reader. Two instances share the clock:
//   A: CLK_DIV=2, AUTO_START=1   B: CLK_DIV=1, AUTO_START=0
// Each has a behavioural flash that returns a 24-bit ID after the opcode.
module tb_spi_jedec_id_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance A
  logic       rst_a, start_a, miso_a, force_a, fval_a;
  logic       cs_n_a, sck_a, mosi_a, busy_a, done_a, idv_a, ide_a;
  logic [7:0] mid_a, mt_a, mc_a;
  logic [23:0] id_a;
  // instance B
  logic       rst_b, start_b, miso_b, force_b, fval_b;
  logic       cs_n_b, sck_b, mosi_b, busy_b, done_b, idv_b, ide_b;
  logic [7:0] mid_b, mt_b, mc_b;
  logic [23:0] id_b;

  spi_jedec_id_reader #(.CLK_DIV(2), .CMD_RDID(8'h9F), .AUTO_START(1'b1)) u_a (
    .clk(clk), .reset(rst_a), .start(start_a), .spi_miso(miso_a),
    .spi_cs_n(cs_n_a), .spi_sck(sck_a), .spi_mosi(mosi_a), .busy(busy_a),
    .done(done_a), .id_valid(idv_a), .id_error(ide_a),
    .manufacture_id(mid_a), .memory_type(mt_a), .memory_capacity(mc_a));

  spi_jedec_id_reader #(.CLK_DIV(1), .CMD_RDID(8'h9F), .AUTO_START(1'b0)) u_b (
    .clk(clk), .reset(rst_b), .start(start_b), .spi_miso(miso_b),
    .spi_cs_n(cs_n_b), .spi_sck(sck_b), .spi_mosi(mosi_b), .busy(busy_b),
    .done(done_b), .id_valid(idv_b), .id_error(ide_b),
    .manufacture_id(mid_b), .memory_type(mt_b), .memory_capacity(mc_b));

  // Flash models: count SCK rises since CS fell; after the 8 opcode bits the
  // ID streams out MSB first. MOSI is captured on every rise.
  int          rise_a = 0, rise_b = 0, stab_a = 0;
  logic [31:0] cap_a = '0, cap_b = '0;

  always @(posedge sck_a or negedge cs_n_a)
    if (sck_a) begin rise_a <= rise_a + 1; cap_a <= {cap_a[30:0], mosi_a}; end
    else       rise_a <= 0;
  always @(posedge sck_b or negedge cs_n_b)
    if (sck_b) begin rise_b <= rise_b + 1; cap_b <= {cap_b[30:0], mosi_b}; end
    else       rise_b <= 0;

  assign miso_a = force_a ? fval_a :
                  ((rise_a >= 8 && rise_a < 32) ? id_a[5'(31 - rise_a)] : 1'b0);
  assign miso_b = force_b ? fval_b :
                  ((rise_b >= 8 && rise_b < 32) ? id_b[5'(31 - rise_b)] : 1'b0);

  // MOSI must not move while SCK is high.
  always @(negedge clk)
    if (sck_a && (mosi_a !== cap_a[0])) stab_a <= stab_a + 1;

  int n_chk = 0, n_err = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  // Reference: done lands 1 + 65*CLK_DIV cycles after the accepting cycle.
  function automatic int exp_done(input int div);
    return 1 + 65 * div;
  endfunction

  function automatic logic exp_err(input logic [23:0] id);
    return (id == 24'h000000) || (id == 24'hFFFFFF);
  endfunction

  task automatic wait_done_a(output int d);
    d = -1;
    for (int i = 0; i < 400; i++) begin
      step(); start_a = 1'b0;
      if (done_a) begin d = cyc; break; end
    end
  endtask

  task automatic wait_done_b(output int d);
    d = -1;
    for (int i = 0; i < 200; i++) begin
      step(); start_b = 1'b0;
      if (done_b) begin d = cyc; break; end
    end
  endtask

  task automatic chk_ids_a(input string tag, input logic [23:0] id);
    chk({tag, "_bytes"}, {8'h00, mid_a, mt_a, mc_a}, {8'h00, id});
    chk({tag, "_err"}, ide_a, exp_err(id));
    chk({tag, "_valid"}, idv_a, 1);
  endtask

  task automatic chk_ids_b(input string tag, input logic [23:0] id);
    chk({tag, "_bytes"}, {8'h00, mid_b, mt_b, mc_b}, {8'h00, id});
    chk({tag, "_err"}, ide_b, exp_err(id));
    chk({tag, "_valid"}, idv_b, 1);
  endtask

  initial begin
    int d, csfall, ndone, nfall, dbl, runlen, minrun, maxrun, holdbad, first;
    logic prev_cs, prev_done;
    logic [23:0] old;
    logic [159:0] pm;

    rst_a = 1; rst_b = 1; start_a = 0; start_b = 0;
    force_a = 0; force_b = 0; fval_a = 0; fval_b = 0;
    id_a = 24'hEF4018; id_b = 24'h000000;
    repeat (3) step();

    // reset state
    chk("rst_pins_a", {cs_n_a, sck_a, mosi_a}, 3'b100);
    chk("rst_flags_a", {busy_a, done_a, idv_a, ide_a}, 4'b0000);
    chk("rst_bytes_a", {mid_a, mt_a, mc_a}, 0);
    chk("rst_pins_b", {cs_n_b, sck_b, mosi_b}, 3'b100);

    // auto-start after reset release, EF 40 18
    rst_a = 0; rst_b = 0; cyc = 0;
    csfall = -1; d = -1;
    for (int i = 0; i < 300 && d < 0; i++) begin
      step();
      if (!cs_n_a && csfall < 0) csfall = cyc;
      if (done_a) d = cyc;
    end
    chk("auto_cs_fall", csfall, 1);
    chk("auto_done_cyc", d, exp_done(2));
    chk("auto_busy_in_done", {busy_a, cs_n_a}, 2'b11);
    chk_ids_a("auto", 24'hEF4018);
    chk("auto_sck_rises", rise_a, 32);
    chk("auto_mosi_bits", cap_a, 32'h9F00_0000);
    chk("auto_mosi_stable", stab_a, 0);
    step();
    chk("auto_after_done", {done_a, busy_a}, 2'b00);
    chk("b_no_autostart", {cs_n_b, busy_b, 8'(rise_b)}, {2'b10, 8'd0});

    // start pulses while busy are ignored
    id_a = 24'($urandom);
    pm = '0;
    for (int k = 0; k < 10; k++) pm[$urandom_range(128, 2)] = 1'b1;
    start_a = 1; cyc = 0;
    ndone = 0; nfall = 0; prev_cs = 1; d = -1;
    for (int c = 1; c <= 170; c++) begin
      step();
      start_a = pm[c];
      if (prev_cs && !cs_n_a) nfall++;
      prev_cs = cs_n_a;
      if (done_a) begin ndone++; d = cyc; end
    end
    chk("busy_start_dones", ndone, 1);
    chk("busy_start_falls", nfall, 1);
    chk("busy_start_done_cyc", d, exp_done(2));
    chk_ids_a("busy_start", id_a);

    // second start: new ID, outputs hold until its done
    old = {mid_a, mt_a, mc_a};
    id_a = 24'hC22017;
    start_a = 1; cyc = 0; holdbad = 0; d = -1;
    for (int i = 0; i < 300 && d < 0; i++) begin
      step(); start_a = 0;
      if (done_a) d = cyc;
      else if ({mid_a, mt_a, mc_a} !== old) holdbad++;
    end
    chk("second_done_cyc", d, exp_done(2));
    chk("second_hold", holdbad, 0);
    chk_ids_a("second", 24'hC22017);
    step();

    // reset during bit 12 of SHIFT, then auto-start again
    id_a = 24'($urandom);
    start_a = 1; cyc = 0; d = -1;
    for (int i = 0; i < 200; i++) begin
      step(); start_a = 0;
      if (rise_a == 12 && !sck_a && !cs_n_a) begin d = cyc; break; end
    end
    chk("mid_reset_reached", d, 1 + 2 * 12 * 2);
    rst_a = 1;
    step();
    chk("mid_reset_pins", {cs_n_a, sck_a, mosi_a}, 3'b100);
    chk("mid_reset_flags", {busy_a, done_a, idv_a, ide_a}, 4'b0000);
    chk("mid_reset_bytes", {mid_a, mt_a, mc_a}, 0);
    step();
    id_a = 24'($urandom);
    rst_a = 0; cyc = 0;
    wait_done_a(d);
    chk("post_reset_done_cyc", d, exp_done(2));
    chk_ids_a("post_reset", id_a);
    chk("post_reset_rises", rise_a, 32);

    // B: MISO stuck high / low
    force_b = 1; fval_b = 1;
    start_b = 1; cyc = 0;
    wait_done_b(d);
    chk("miso_hi_done_cyc", d, exp_done(1));
    chk_ids_b("miso_hi", 24'hFFFFFF);
    chk("b_mosi_bits", cap_b, 32'h9F00_0000);
    repeat (3) step();
    fval_b = 0;
    start_b = 1; cyc = 0;
    wait_done_b(d);
    chk("miso_lo_done_cyc", d, exp_done(1));
    chk_ids_b("miso_lo", 24'h000000);
    force_b = 0;

    // B: random IDs
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(4, 1)) step();
      id_b = 24'($urandom);
      start_b = 1; cyc = 0;
      wait_done_b(d);
      chk("rand_done_cyc", d, exp_done(1));
      chk_ids_b("rand", id_b);
    end

    // B: start held for 400 cycles -> back-to-back transactions
    repeat (3) step();
    start_b = 1; cyc = 0;
    ndone = 0; nfall = 0; dbl = 0; runlen = 0; minrun = 999; maxrun = 0;
    first = -1; prev_cs = 1; prev_done = 0;
    for (int c = 1; c <= 430; c++) begin
      step();
      if (cyc == 400) start_b = 0;
      if (prev_cs && !cs_n_b) begin
        if (nfall > 0) begin
          if (runlen < minrun) minrun = runlen;
          if (runlen > maxrun) maxrun = runlen;
        end
        nfall++;
      end
      runlen = cs_n_b ? runlen + 1 : 0;
      prev_cs = cs_n_b;
      if (done_b) begin
        if (first < 0) first = cyc;
        ndone++;
        if (prev_done) dbl++;
      end
      prev_done = done_b;
    end
    chk("b2b_first_done", first, exp_done(1));
    chk("b2b_dones", ndone, 6);
    chk("b2b_falls", nfall, 6);
    chk("b2b_cs_high_min", minrun, 2);
    chk("b2b_cs_high_max", maxrun, 2);
    chk("b2b_done_single", dbl, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
